// File: rtl/mips_pkg.sv
// Shared MIPS opcode constants and per-opcode operand/destination helpers,
// reused by the decode stage, the control unit and the forwarding unit.
package mips_pkg;

  localparam int OPCODE_W = 6;
  localparam int FUNCT_W  = 6;
  localparam int REG_W    = 5;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPCODE_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b000011;

  localparam logic [REG_W-1:0] REG_RA = 5'd31;

  typedef enum logic [1:0] {DST_NONE, DST_RD, DST_RT, DST_RA} dstSel_e;

  function automatic logic usesRs(input logic [OPCODE_W-1:0] op);
    return !(op == OP_J || op == OP_JAL || op == OP_LUI);
  endfunction

  function automatic logic usesRt(input logic [OPCODE_W-1:0] op);
    return (op == OP_RTYPE || op == OP_SW || op == OP_BEQ || op == OP_BNE);
  endfunction

  function automatic dstSel_e destSel(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_RTYPE:                                       return DST_RD;
      OP_LW, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: return DST_RT;
      OP_JAL:                                         return DST_RA;
      default:                                        return DST_NONE;
    endcase
  endfunction

  // Logical immediates are zero-extended; lui's upper shift happens in EX.
  function automatic logic zeroExtImm(input logic [OPCODE_W-1:0] op);
    return (op == OP_ANDI || op == OP_ORI || op == OP_LUI);
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational instruction decode: field split, immediate extension,
// destination select and operand-usage flags.
module id_decode
  import mips_pkg::*;
(
  input  logic [31:0]         instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [FUNCT_W-1:0]  funct,
  output logic [REG_W-1:0]    rs,
  output logic [REG_W-1:0]    rt,
  output logic [REG_W-1:0]    dst,
  output logic [31:0]         imm,
  output logic                regWrite,
  output logic                memRead,
  output logic                memWrite,
  output logic                useRs,
  output logic                useRt
);

  dstSel_e dSel;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign funct  = instr[5:0];
  assign dSel   = destSel(opcode);
  assign useRs  = usesRs(opcode);
  assign useRt  = usesRt(opcode);

  always_comb begin
    dst = '0;
    case (dSel)
      DST_RD:  dst = instr[15:11];
      DST_RT:  dst = instr[20:16];
      DST_RA:  dst = REG_RA;
      default: dst = '0;
    endcase
  end

  // Writes to $0 are architecturally dropped, so never mark them as writes.
  assign regWrite = (dSel != DST_NONE) && (dst != '0);
  assign memRead  = (opcode == OP_LW);
  assign memWrite = (opcode == OP_SW);

  assign imm = zeroExtImm(opcode) ? {16'b0, instr[15:0]}
                                  : {{16{instr[15]}}, instr[15:0]};

endmodule

// File: rtl/id_ex_stage.sv
// ID stage with writeback bypass and load-use detection, feeding the ID/EX
// pipeline register consumed by the ALU and forwarding logic.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [31:0]         id_instr,
  input  logic [31:0]         id_pc_plus4,
  output logic [REG_W-1:0]    rf_addr1,
  output logic [REG_W-1:0]    rf_addr2,
  input  logic [31:0]         rf_data1,
  input  logic [31:0]         rf_data2,
  input  logic                wb_we,
  input  logic [REG_W-1:0]    wb_addr,
  input  logic [31:0]         wb_data,
  input  logic                flush,
  input  logic                ex_stall,
  output logic                id_stall,
  output logic                ex_valid,
  output logic [31:0]         ex_pc_plus4,
  output logic [31:0]         ex_op1,
  output logic [31:0]         ex_op2,
  output logic [31:0]         ex_imm,
  output logic [REG_W-1:0]    ex_rs,
  output logic [REG_W-1:0]    ex_rt,
  output logic [REG_W-1:0]    ex_dst,
  output logic [OPCODE_W-1:0] ex_opcode,
  output logic [FUNCT_W-1:0]  ex_funct,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write
);

  logic [OPCODE_W-1:0] opcode;
  logic [FUNCT_W-1:0]  funct;
  logic [REG_W-1:0]    rs, rt, dst;
  logic [31:0]         imm;
  logic                regWrite, memRead, memWrite, useRs, useRt;
  logic [31:0]         op1Byp, op2Byp;
  logic                loadUse;

  id_decode u_decode (
    .instr    (id_instr),
    .opcode   (opcode),
    .funct    (funct),
    .rs       (rs),
    .rt       (rt),
    .dst      (dst),
    .imm      (imm),
    .regWrite (regWrite),
    .memRead  (memRead),
    .memWrite (memWrite),
    .useRs    (useRs),
    .useRt    (useRt)
  );

  assign rf_addr1 = rs;
  assign rf_addr2 = rt;

  // The register file write only lands at the edge, so merge it here.
  assign op1Byp = (wb_we && wb_addr != '0 && wb_addr == rs) ? wb_data : rf_data1;
  assign op2Byp = (wb_we && wb_addr != '0 && wb_addr == rt) ? wb_data : rf_data2;

  assign loadUse = id_valid && ex_valid && ex_mem_read && (ex_dst != '0) &&
                   ((useRs && ex_dst == rs) || (useRt && ex_dst == rt));

  assign id_stall = id_valid && !flush && (ex_stall || loadUse);

  // ID/EX boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_pc_plus4  <= '0;
      ex_op1       <= '0;
      ex_op2       <= '0;
      ex_imm       <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_dst       <= '0;
      ex_opcode    <= '0;
      ex_funct     <= '0;
    end else if (flush || (!ex_stall && loadUse)) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid     <= id_valid;
      ex_reg_write <= id_valid && regWrite;
      ex_mem_read  <= id_valid && memRead;
      ex_mem_write <= id_valid && memWrite;
      ex_pc_plus4  <= id_pc_plus4;
      ex_op1       <= op1Byp;
      ex_op2       <= op2Byp;
      ex_imm       <= imm;
      ex_rs        <= rs;
      ex_rt        <= rt;
      ex_dst       <= dst;
      ex_opcode    <= opcode;
      ex_funct     <= funct;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic [4:0]  rf_addr1, rf_addr2;
  logic [31:0] rf_data1, rf_data2;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush, ex_stall, id_stall;
  logic        ex_valid;
  logic [31:0] ex_pc_plus4, ex_op1, ex_op2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_dst;
  logic [5:0]  ex_opcode, ex_funct;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc_plus4  (id_pc_plus4),
    .rf_addr1     (rf_addr1),
    .rf_addr2     (rf_addr2),
    .rf_data1     (rf_data1),
    .rf_data2     (rf_data2),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .flush        (flush),
    .ex_stall     (ex_stall),
    .id_stall     (id_stall),
    .ex_valid     (ex_valid),
    .ex_pc_plus4  (ex_pc_plus4),
    .ex_op1       (ex_op1),
    .ex_op2       (ex_op2),
    .ex_imm       (ex_imm),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_dst       (ex_dst),
    .ex_opcode    (ex_opcode),
    .ex_funct     (ex_funct),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_instr = '0; id_pc_plus4 = '0;
    rf_data1 = '0; rf_data2 = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    flush = 1'b0; ex_stall = 1'b0;
    step(); step();
    checkEq("rst_valid", 32'(ex_valid), 32'd0);
    checkEq("rst_stall", 32'(id_stall), 32'd0);
    rst = 1'b0;

    // addi $8,$9,-4
    id_valid = 1'b1; id_pc_plus4 = 32'h0000_0104;
    id_instr = itype(6'b001000, 5'd9, 5'd8, 16'hFFFC);
    rf_data1 = 32'h10; rf_data2 = 32'h99;
    #1;
    checkEq("addi_rfaddr1", 32'(rf_addr1), 32'd9);
    step();
    checkEq("addi_valid", 32'(ex_valid), 32'd1);
    checkEq("addi_op1", ex_op1, 32'h10);
    checkEq("addi_imm", ex_imm, 32'hFFFF_FFFC);
    checkEq("addi_dst", 32'(ex_dst), 32'd8);
    checkEq("addi_rw", 32'(ex_reg_write), 32'd1);
    checkEq("addi_pc", ex_pc_plus4, 32'h0000_0104);

    // add $3,$5,$6 with writeback bypass, then with wb_addr=0
    id_instr = rtype(5'd5, 5'd6, 5'd3, 6'h20);
    rf_data1 = 32'h1; rf_data2 = 32'h2;
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hAAAA_0000;
    step();
    checkEq("byp_op1", ex_op1, 32'hAAAA_0000);
    checkEq("byp_op2", ex_op2, 32'h2);
    checkEq("byp_dst", 32'(ex_dst), 32'd3);
    wb_addr = 5'd0;
    step();
    checkEq("byp0_op1", ex_op1, 32'h1);
    wb_addr = 5'd6; wb_data = 32'h6666_0000;
    step();
    checkEq("byp_rt_op2", ex_op2, 32'h6666_0000);
    wb_we = 1'b0; wb_addr = '0;

    // lw $4,0($1) then sub $2,$4,$7
    id_instr = itype(6'b100011, 5'd1, 5'd4, 16'h0000);
    step();
    checkEq("lw_memrd", 32'(ex_mem_read), 32'd1);
    id_instr = rtype(5'd4, 5'd7, 5'd2, 6'h22);
    rf_data1 = 32'h4444;
    #1;
    checkEq("lu_stall", 32'(id_stall), 32'd1);
    step();
    checkEq("lu_bubble", 32'(ex_valid), 32'd0);
    checkEq("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
    checkEq("lu_stall_clr", 32'(id_stall), 32'd0);
    step();
    checkEq("lu_sub_valid", 32'(ex_valid), 32'd1);
    checkEq("lu_sub_rs", 32'(ex_rs), 32'd4);
    checkEq("lu_sub_funct", 32'(ex_funct), 32'h22);
    checkEq("lu_sub_op1", ex_op1, 32'h4444);

    // lw then ori $4,$2,0x8001: rt is only a destination, no hazard
    id_instr = itype(6'b100011, 5'd1, 5'd4, 16'h0000);
    step();
    id_instr = itype(6'b001101, 5'd2, 5'd4, 16'h8001);
    #1;
    checkEq("ori_nostall", 32'(id_stall), 32'd0);
    step();
    checkEq("ori_valid", 32'(ex_valid), 32'd1);
    checkEq("ori_imm", ex_imm, 32'h0000_8001);

    // EX stall for three cycles holds the addi
    id_instr = itype(6'b001000, 5'd9, 5'd8, 16'hFFFC);
    rf_data1 = 32'h10;
    step();
    ex_stall = 1'b1;
    id_instr = itype(6'b001100, 5'd9, 5'd3, 16'h00FF);
    rf_data1 = 32'h55; wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkEq("stall_idstall", 32'(id_stall), 32'd1);
      step();
      checkEq("stall_op1", ex_op1, 32'h10);
      checkEq("stall_dst", 32'(ex_dst), 32'd8);
      checkEq("stall_opcode", 32'(ex_opcode), 32'h08);
    end
    wb_we = 1'b0; wb_addr = '0;
    flush = 1'b1;
    #1;
    checkEq("flush_idstall", 32'(id_stall), 32'd0);
    step();
    checkEq("flush_valid", 32'(ex_valid), 32'd0);
    checkEq("flush_rw", 32'(ex_reg_write), 32'd0);
    flush = 1'b0; ex_stall = 1'b0;

    // lw $5 then jal whose target bits alias rs=5
    id_instr = itype(6'b100011, 5'd1, 5'd5, 16'h0000);
    step();
    id_instr = {6'b000011, 5'd5, 21'd0};
    #1;
    checkEq("jal_nostall", 32'(id_stall), 32'd0);
    step();
    checkEq("jal_dst", 32'(ex_dst), 32'd31);
    checkEq("jal_rw", 32'(ex_reg_write), 32'd1);
    checkEq("jal_memrd", 32'(ex_mem_read), 32'd0);

    // Illegal opcode 0x3F behaves as a valid NOP
    id_instr = {6'h3F, 5'd0, 5'd9, 16'h1234};
    step();
    checkEq("ill_valid", 32'(ex_valid), 32'd1);
    checkEq("ill_ctl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
    checkEq("ill_dst", 32'(ex_dst), 32'd0);

    // sw and lui
    id_instr = itype(6'b101011, 5'd1, 5'd2, 16'h0004);
    step();
    checkEq("sw_ctl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd1);
    id_instr = itype(6'b001111, 5'd0, 5'd7, 16'h8000);
    step();
    checkEq("lui_imm", ex_imm, 32'h0000_8000);
    checkEq("lui_dst", 32'(ex_dst), 32'd7);

    // id_valid low loads an invalid, control-free slot
    id_valid = 1'b0;
    id_instr = itype(6'b001000, 5'd9, 5'd8, 16'hFFFC);
    step();
    checkEq("inv_valid", 32'(ex_valid), 32'd0);
    checkEq("inv_rw", 32'(ex_reg_write), 32'd0);

    // Asynchronous reset in the middle of a stall
    id_valid = 1'b1;
    rf_data1 = 32'h10;
    step();
    ex_stall = 1'b1;
    step();
    #2;
    rst = 1'b1; id_valid = 1'b0;
    #1;
    checkEq("arst_valid", 32'(ex_valid), 32'd0);
    checkEq("arst_op1", ex_op1, 32'd0);
    checkEq("arst_dst", 32'(ex_dst), 32'd0);
    checkEq("arst_idstall", 32'(id_stall), 32'd0);
    ex_stall = 1'b0;
    step();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the MIPS core. It drives the register file read addresses from the IF/ID instruction and takes the two read-data words back. It merges a same-cycle writeback bypass, because the register file write lands only at the clock edge, and it detects load-use hazards. It registers operands, immediate and control into the ID/EX boundary consumed by the ALU/forwarding logic.

## Interface
- No parameters; opcode and field constants come from the shared package.
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: asynchronous, active-high; clears all registered outputs.
- `id_valid` in 1: IF/ID holds a real instruction.
- `id_instr` in 32: IF/ID instruction word.
- `id_pc_plus4` in 32: IF/ID PC+4.
- `rf_addr1`, `rf_addr2` out 5: combinational `id_instr[25:21]`, `id_instr[20:16]` to register file read ports.
- `rf_data1`, `rf_data2` in 32: register file read data; register 0 already reads 0.
- `wb_we` in 1, `wb_addr` in 5, `wb_data` in 32: writeback port, same signals that drive the register file write.
- `flush` in 1: branch/jump resolved downstream; kill ID and EX contents.
- `ex_stall` in 1: EX cannot accept; hold ID/EX register.
- `id_stall` out 1: combinational; IF/ID and PC must hold this cycle.
- `ex_valid` out 1; `ex_pc_plus4` out 32; `ex_op1`, `ex_op2` out 32; `ex_imm` out 32.
- `ex_rs`, `ex_rt`, `ex_dst` out 5; `ex_opcode`, `ex_funct` out 6.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write` out 1.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, slti 001010, andi 001100, ori 001101, lui 001111, j 000010, jal 000011. Any other opcode is treated as a NOP: valid, all write/mem controls 0.
- Uses-rs: every opcode except j, jal, lui. Uses-rt: R-type, sw, beq, bne.
- Dest: R-type uses rd `[15:11]`. lw/addi/slti/andi/ori/lui use rt. jal uses 31. Others have `reg_write`=0 and `dst`=0. A dst of 0 forces `reg_write`=0.
- Immediate: andi, ori and lui zero-extend `[15:0]`. All others sign-extend. lui shifting is EX's job.
- Bypass per operand: if `wb_we` and `wb_addr`≠0 and `wb_addr`==rs (rt), use `wb_data`; otherwise use `rf_data`.
- Load-use: `ex_valid` & `ex_mem_read` & `ex_dst`≠0 & ((uses-rs & `ex_dst`==rs) | (uses-rt & `ex_dst`==rt)), qualified by `id_valid`.
- Register update priority:
  - `rst`: async clear.
  - `flush`: ex_valid and all controls 0.
  - `ex_stall`: hold all.
  - Load-use: insert bubble; ex_valid and controls 0, data fields don't-care.
  - Otherwise: load decoded ID values; `ex_valid`=`id_valid`. If `id_valid`=0, controls are 0.
- `id_stall` = `id_valid` & ~`flush` & (`ex_stall` | load-use).
- No FSM. State is the ID/EX register only.

## Timing
- All `ex_*` outputs reset to 0. `id_stall` is 0 under reset because `flush` and `id_valid` are expected low, and it is not registered.
- Latency: an instruction present at edge N appears on `ex_*` after edge N.
- Load-use costs exactly one bubble cycle. The following cycle the load is in MEM, hazard clears and the consumer advances; the downstream forwarding unit covers it.
- Simultaneous `flush` and `ex_stall`: flush wins and `id_stall`=0.
- Simultaneous load-use and `ex_stall`: hold, not bubble.
- Bypass applies only when operands are captured. Held operands are never refreshed.
- `rst` asserted mid-stall: outputs clear immediately, with no dependency on `clk`.

## Structure
- Shared package `mips_pkg`: opcode localparams, funct width, `REG_RA`=31, and uses-rs/uses-rt/dest-select functions. These are reused by the control unit and the forwarding unit.
- One natural sub-module, `id_decode`: a combinational field split, immediate extension, dest select and uses flags. The top holds the bypass muxes, hazard detection and the ID/EX register.

## Test plan
- Reset: assert `rst` mid-run with ex_valid=1 → all `ex_*`=0 before the next edge; `id_stall`=0.
- `addi $8,$9,-4` with rf_data1=0x10 → ex_op1=0x10, ex_imm=0xFFFFFFFC, ex_dst=8, ex_reg_write=1, one cycle later.
- WB bypass: `add $3,$5,$6` with wb_we=1, wb_addr=5, wb_data=0xAAAA0000, rf_data1=0x1 → ex_op1=0xAAAA0000. Repeat with wb_addr=0 → ex_op1=0x1.
- Load-use: `lw $4,0($1)` followed by `sub $2,$4,$7` → id_stall=1 for exactly one cycle, an ex_valid=0 bubble, then sub with ex_rs=4. `ori $4,...` after the lw → no stall.
- Flush and stall: ex_stall=1 for 3 cycles → ex_* constant and id_stall=1. Assert flush together with ex_stall → ex_valid=0 next edge and id_stall=0.
- jal → ex_dst=31, ex_reg_write=1, no stall even if the EX load targets rs field bits. Illegal opcode 0x3F → ex_valid=1, all controls 0.
